// File: rtl/pulse_gen_meter_if.sv
// rtl/pulse_gen_meter_if.sv - trigger/echo stimulus and measurement result bundle
interface pulse_gen_meter_if #(
    parameter int CHANNELS = 4,
    parameter int LEN_W    = 8,
    parameter int COUNT_W  = 16
);
    logic                        i_Signal;
    logic [LEN_W-1:0]            i_Pulse_Len;
    logic [COUNT_W-1:0]          i_Timeout;
    logic [CHANNELS-1:0]         i_Echo;
    logic                        o_Impulse;
    logic                        o_ready;
    logic                        o_Valid;
    logic [CHANNELS*COUNT_W-1:0] o_Time;
    logic [CHANNELS-1:0]         o_Hit;
    logic                        o_Timeout;
    logic                        o_Missed;

    // Stimulus side: drives trigger, configuration and echoes
    modport master (
        output i_Signal, i_Pulse_Len, i_Timeout, i_Echo,
        input  o_Impulse, o_ready, o_Valid, o_Time, o_Hit, o_Timeout, o_Missed
    );

    // Meter side
    modport slave (
        input  i_Signal, i_Pulse_Len, i_Timeout, i_Echo,
        output o_Impulse, o_ready, o_Valid, o_Time, o_Hit, o_Timeout, o_Missed
    );
endinterface

// File: rtl/pulse_gen_meter.sv
// rtl/pulse_gen_meter.sv - impulse generator with per-channel echo time-of-flight capture
module pulse_gen_meter #(
    parameter int CHANNELS = 4,
    parameter int LEN_W    = 8,
    parameter int COUNT_W  = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    pulse_gen_meter_if.slave bus
);
    localparam int CMP_W = (LEN_W > COUNT_W) ? LEN_W : COUNT_W;

    typedef enum logic [1:0] {IDLE, PULSE, LISTEN, DONE} state_t;

    state_t                      state_q, state_d;
    logic                        sig_prev_q;
    logic [CHANNELS-1:0]         echo_prev_q;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [COUNT_W-1:0]          tmo_q, tmo_d;
    logic [COUNT_W-1:0]          count_q, count_d;
    logic [CHANNELS*COUNT_W-1:0] time_q, time_d;
    logic [CHANNELS-1:0]         hit_q, hit_d;
    logic                        tflag_q, tflag_d;
    logic                        missed_q, missed_d;

    logic                        trig;
    logic                        active;
    logic [CHANNELS-1:0]         echo_rise;
    logic [CHANNELS-1:0]         cap;
    logic                        hit_all;
    logic                        window_end;
    logic                        pulse_end;
    logic [CMP_W-1:0]            count_ext;
    logic [CMP_W-1:0]            len_last;

    assign trig       = bus.i_Signal & ~sig_prev_q;
    assign active     = (state_q == PULSE) || (state_q == LISTEN);
    assign echo_rise  = bus.i_Echo & ~echo_prev_q;
    // Only the first rising edge per channel in a shot is captured
    assign cap        = echo_rise & ~hit_q & {CHANNELS{active}};
    assign hit_all    = &(hit_q | cap);
    assign window_end = (count_q == tmo_q);
    assign count_ext  = CMP_W'(count_q);
    assign len_last   = CMP_W'(len_q) - CMP_W'(1);
    assign pulse_end  = (count_ext == len_last);

    // State register; reset wins over everything, including a running shot
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: all-hit or window expiry ends the shot even mid-impulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig) state_d = PULSE;
            PULSE: begin
                if (hit_all || window_end) state_d = DONE;
                else if (pulse_end)        state_d = LISTEN;
            end
            LISTEN:  if (hit_all || window_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: strobes decode the state, results come straight from registers
    always_comb begin
        bus.o_Impulse = (state_q == PULSE);
        bus.o_ready   = (state_q == IDLE);
        bus.o_Valid   = (state_q == DONE);
        bus.o_Time    = time_q;
        bus.o_Hit     = hit_q;
        bus.o_Timeout = tflag_q;
        bus.o_Missed  = missed_q;
    end

    // Datapath next values: shot setup, counting, capture and miss flagging
    always_comb begin
        len_d    = len_q;
        tmo_d    = tmo_q;
        count_d  = count_q;
        time_d   = time_q;
        hit_d    = hit_q;
        tflag_d  = tflag_q;
        missed_d = missed_q;
        if (state_q == IDLE) begin
            if (trig) begin
                // A zero length still launches a one-cycle impulse
                len_d    = (bus.i_Pulse_Len == '0) ? LEN_W'(1) : bus.i_Pulse_Len;
                tmo_d    = bus.i_Timeout;
                count_d  = '0;
                time_d   = '0;
                hit_d    = '0;
                tflag_d  = 1'b0;
                missed_d = 1'b0;
            end
        end else if (trig) begin
            missed_d = 1'b1;
        end
        if (active) begin
            hit_d = hit_q | cap;
            for (int c = 0; c < CHANNELS; c++) begin
                if (cap[c]) time_d[c*COUNT_W +: COUNT_W] = count_q;
            end
            if (hit_all || window_end) begin
                // A capture in the expiry cycle still completes the set
                tflag_d = ~hit_all;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (!hit_d[c]) time_d[c*COUNT_W +: COUNT_W] = '1;
                end
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    // Datapath registers; edge detectors reset high so held-high inputs do not fire
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sig_prev_q  <= 1'b1;
            echo_prev_q <= '1;
            len_q       <= '0;
            tmo_q       <= '0;
            count_q     <= '0;
            time_q      <= '0;
            hit_q       <= '0;
            tflag_q     <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            sig_prev_q  <= bus.i_Signal;
            echo_prev_q <= bus.i_Echo;
            len_q       <= len_d;
            tmo_q       <= tmo_d;
            count_q     <= count_d;
            time_q      <= time_d;
            hit_q       <= hit_d;
            tflag_q     <= tflag_d;
            missed_q    <= missed_d;
        end
    end
endmodule

// File: tb/tb_pulse_gen_meter.sv
// tb/tb_pulse_gen_meter.sv - directed scoreboard bench for pulse_gen_meter
module tb_pulse_gen_meter;
    localparam int CH = 4;
    localparam int LW = 8;
    localparam int CW = 16;

    typedef struct {
        logic [CH*CW-1:0] t;
        logic [CH-1:0]    h;
        logic             tf;
        int               vcyc;
    } exp_t;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    pulse_gen_meter_if #(.CHANNELS(CH), .LEN_W(LW), .COUNT_W(CW)) bus ();

    pulse_gen_meter #(.CHANNELS(CH), .LEN_W(LW), .COUNT_W(CW)) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Result strobe: pop the oldest expected shot and compare everything
    always @(negedge i_Clk) begin
        if (!i_Rst && bus.o_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(bus.o_Valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_cycle", 64'(cyc), 64'(e.vcyc));
                check("time", 64'(bus.o_Time), 64'(e.t));
                check("hit", 64'(bus.o_Hit), 64'(e.h));
                check("timeout", 64'(bus.o_Timeout), 64'(e.tf));
            end
        end
    end

    // One shot: model the outcome, fire the trigger, play echoes by count
    task automatic run_shot(input int len, input int tmo, input int e0, input int e1,
                            input int e2, input int e3, input int hold2, input int retrig);
        int               e[CH];
        int               fin;
        int               imp;
        int               base;
        int               len_eff;
        logic [CH*CW-1:0] t;
        logic [CH-1:0]    h;
        logic             tf;
        logic [CH-1:0]    ev;
        exp_t             x;
        e = '{e0, e1, e2, e3};
        t = '0;
        h = '0;
        tf = 1'b0;
        fin = tmo;
        for (int n = 0; n <= tmo; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (e[c] == n && !h[c]) begin
                    h[c] = 1'b1;
                    t[c*CW +: CW] = CW'(n);
                end
            end
            if (&h) begin
                fin = n;
                tf = 1'b0;
                break;
            end
            if (n == tmo) begin
                fin = n;
                tf = 1'b1;
            end
        end
        for (int c = 0; c < CH; c++) if (!h[c]) t[c*CW +: CW] = '1;
        len_eff = (len == 0) ? 1 : len;

        bus.i_Echo = (hold2 > 0) ? 4'b0100 : 4'b0000;
        bus.i_Signal = 1'b0;
        tick();
        tick();
        bus.i_Pulse_Len = LW'(len);
        bus.i_Timeout = CW'(tmo);
        bus.i_Signal = 1'b1;
        tick();
        base = cyc;
        x.t = t;
        x.h = h;
        x.tf = tf;
        x.vcyc = base + fin + 1;
        exp_q.push_back(x);
        bus.i_Signal = 1'b0;
        imp = 0;
        for (int n = 0; n <= fin; n++) begin
            if (bus.o_Impulse === 1'b1) imp++;
            if (n == 0) check("missed_cleared", 64'(bus.o_Missed), 64'd0);
            for (int c = 0; c < CH; c++) ev[c] = (e[c] == n) || (c == 2 && n < hold2);
            bus.i_Echo = ev;
            bus.i_Signal = (n == retrig);
            tick();
        end
        bus.i_Echo = '0;
        bus.i_Signal = 1'b0;
        tick();
        check("ready_after", 64'(bus.o_ready), 64'd1);
        check("impulse_len", 64'(imp), 64'((len_eff < fin + 1) ? len_eff : fin + 1));
        check("missed", 64'(bus.o_Missed), 64'(retrig >= 0));
        tick();
        tick();
        check("hold_time", 64'(bus.o_Time), 64'(t));
        check("hold_hit", 64'(bus.o_Hit), 64'(h));
        check("hold_timeout", 64'(bus.o_Timeout), 64'(tf));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
        check({tag, "_impulse"}, 64'(bus.o_Impulse), 64'd0);
        check({tag, "_valid"}, 64'(bus.o_Valid), 64'd0);
        check({tag, "_hit"}, 64'(bus.o_Hit), 64'd0);
        check({tag, "_time"}, 64'(bus.o_Time), 64'd0);
        check({tag, "_timeout"}, 64'(bus.o_Timeout), 64'd0);
        check({tag, "_missed"}, 64'(bus.o_Missed), 64'd0);
    endtask

    initial begin
        bus.i_Signal = 1'b1;
        bus.i_Pulse_Len = '0;
        bus.i_Timeout = '0;
        bus.i_Echo = '0;
        i_Rst = 1'b1;
        tick();
        tick();
        tick();
        check_reset_state("reset");
        i_Rst = 1'b0;
        tick();
        tick();
        tick();
        check("no_start_held_trigger", 64'(bus.o_ready), 64'd1);

        run_shot(3, 100, 5, 7, 9, 11, 0, -1);
        run_shot(4, 20, 4, -1, -1, -1, 0, -1);
        run_shot(0, 30, 5, 5, 5, 5, 0, -1);
        run_shot(5, 100, 2, 3, 12, 15, 0, 10);
        run_shot(3, 50, 1, 2, 3, 4, 0, -1);
        run_shot(3, 40, 4, 5, 6, 8, 3, -1);
        run_shot(2, 10, 3, 10, 5, 10, 0, -1);
        run_shot(2, 10, 10, 2, -1, -1, 0, -1);
        run_shot(8, 50, 2, 2, 2, 2, 0, -1);

        // Reset in LISTEN at count 8 with the trigger held high
        bus.i_Signal = 1'b0;
        tick();
        bus.i_Pulse_Len = LW'(3);
        bus.i_Timeout = CW'(100);
        bus.i_Signal = 1'b1;
        tick();
        for (int n = 0; n < 8; n++) tick();
        check("midshot_busy", 64'(bus.o_ready), 64'd0);
        i_Rst = 1'b1;
        tick();
        check_reset_state("midshot_reset");
        i_Rst = 1'b0;
        tick();
        tick();
        tick();
        check("no_restart_held", 64'(bus.o_ready), 64'd1);
        bus.i_Signal = 1'b0;

        run_shot(3, 100, 5, 7, 9, 11, 0, -1);

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
